multicycle_ctrl: RTL and testbench

- Moore FSM controller for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback. Drives datapath enables, operand selects and the 2-bit ResultSrc select of the writeback 3:1 mux.
- Supports variable-latency memory through a req/ready handshake, with a watchdog counter.
- Traps on illegal opcodes and memory timeouts.

---
 rtl/rv32i_ctrl_pkg.sv | 44 ++++
 rtl/multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller:
// FSM states, opcodes, writeback/ALU operand select codes.
package rv32i_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        TRAP
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Writeback mux select; 2'b11 is never driven.
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PCN = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with memory handshake watchdog.
// In: CLK, RST, opcode, zero_flag, mem_ready. Out: datapath
// enables/selects, instr_retired pulse, sticky trap flags.
module multicycle_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] opcode,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic       mem_fault
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE   = 1;
    localparam bit               WD_EN = (MEM_TIMEOUT != 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ill_q, ill_d;
    logic               flt_q, flt_d;
    logic               load_q, load_d;
    logic               waiting;
    logic               timeout;

    assign waiting = (state_q == FETCH || state_q == MEMREAD ||
                      state_q == MEMWRITE) && !mem_ready;
    // mem_ready in the limit cycle wins: waiting is already false.
    assign timeout = WD_EN && waiting && (cnt_q == LIMIT);
    // Only stalled cycles count; any completion or other state clears.
    assign cnt_d   = waiting ? cnt_q + ONE : '0;

    always_comb begin
        state_d = state_q;
        ill_d   = ill_q;
        flt_d   = flt_q;
        load_d  = load_q;
        unique case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                // IR is loaded on the ir_write edge, so the opcode
                // input is first valid here; keep what MEMADR needs.
                load_d = (opcode == OP_LOAD);
                unique case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    default: begin
                        state_d = TRAP;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = load_q ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            MEMWB:    state_d = FETCH;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = FETCH;
            default:  state_d = TRAP;
        endcase
        if (timeout) begin
            state_d = TRAP;
            flt_d   = 1'b1;
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        reg_write     = 1'b0;
        result_src    = RESULT_ALU;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        instr_retired = 1'b0;
        if (!RST) begin
            unique case (state_q)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                MEMWB: begin
                    result_src    = RESULT_MEM;
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                MEMWRITE: begin
                    mem_req       = 1'b1;
                    mem_write     = 1'b1;
                    adr_src       = 1'b1;
                    instr_retired = mem_ready;
                end
                EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_FUNCT;
                end
                EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                end
                ALUWB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = SRCA_RS1;
                    alu_op        = ALUOP_BRANCH;
                    pc_src        = 1'b1;
                    pc_write      = zero_flag;
                    instr_retired = 1'b1;
                end
                JAL: begin
                    result_src    = RESULT_PCN;
                    reg_write     = 1'b1;
                    pc_src        = 1'b1;
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Flags are registered; mask them so reset reads all-zero at once.
    assign illegal_instr = ill_q & ~RST;
    assign mem_fault     = flt_q & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            flt_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            flt_q   <= flt_d;
            load_q  <= load_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl (MEM_TIMEOUT=4).
// Expected output vectors queued per cycle, checked at negedge.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic       zero_flag = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write;
    logic       pc_write, pc_src, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       instr_retired, illegal_instr, mem_fault;

    always #5 CLK = ~CLK;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode),
        .zero_flag(zero_flag), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .instr_retired(instr_retired),
        .illegal_instr(illegal_instr), .mem_fault(mem_fault)
    );

    typedef enum int {R, F, D, MA, MR, MWB, MW, ER, EI, AWB, BR, J, T} st_t;

    logic [17:0] sb[$];
    int vectors = 0;
    int miscompares = 0;
    logic ill_e = 1'b0;
    logic flt_e = 1'b0;

    function automatic logic [17:0] ex(input st_t s);
        logic mq, mw, ad, iw, pw, ps, rw, rt;
        logic [1:0] rs, a, b, op;
        {mq, mw, ad, iw, pw, ps, rw, rt} = 8'b0;
        {rs, a, b, op} = 8'b0;
        case (s)
            F:   begin mq = 1; b = 2'b10; iw = mem_ready; pw = mem_ready; end
            D:   begin a = 2'b01; b = 2'b01; end
            MA:  begin a = 2'b10; b = 2'b01; end
            MR:  begin mq = 1; ad = 1; end
            MWB: begin rs = 2'b01; rw = 1; rt = 1; end
            MW:  begin mq = 1; mw = 1; ad = 1; rt = mem_ready; end
            ER:  begin a = 2'b10; op = 2'b10; end
            EI:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
            AWB: begin rw = 1; rt = 1; end
            BR:  begin a = 2'b10; op = 2'b01; ps = 1; pw = zero_flag; rt = 1; end
            J:   begin rs = 2'b10; rw = 1; ps = 1; pw = 1; rt = 1; end
            default: ;
        endcase
        return {mq, mw, ad, iw, pw, ps, rw, rs, a, b, op, rt,
                (s == R) ? 1'b0 : ill_e, (s == R) ? 1'b0 : flt_e};
    endfunction

    task automatic cyc(input string tag, input st_t s);
        logic [17:0] e, o;
        sb.push_back(ex(s));
        @(negedge CLK);
        e = sb.pop_front();
        o = {mem_req, mem_write, adr_src, ir_write, pc_write, pc_src,
             reg_write, result_src, alu_src_a, alu_src_b, alu_op,
             instr_retired, illegal_instr, mem_fault};
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        mem_ready = 1'b1;
        cyc("rst_a", R);
        cyc("rst_b", R);
        RST = 1'b0;
        opcode = 7'b0000011;
        cyc("lw0_f", F);
        cyc("lw0_d", D);
        cyc("lw0_ma", MA);
        mem_ready = 1'b0;
        cyc("lw0_mr", MR);
        cyc("lw0_mr", MR);
        RST = 1'b1;
        repeat (3) cyc("rst_mid", R);
        RST = 1'b0;
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        cyc("r_f", F);
        cyc("r_d", D);
        opcode = 7'b1111111;
        cyc("r_ex", ER);
        cyc("r_wb", AWB);
        opcode = 7'b0000011;
        cyc("lw_f", F);
        cyc("lw_d", D);
        opcode = 7'b0100011;
        cyc("lw_ma", MA);
        mem_ready = 1'b0;
        repeat (3) cyc("lw_wait", MR);
        mem_ready = 1'b1;
        cyc("lw_mr", MR);
        cyc("lw_wb", MWB);
        opcode = 7'b0100011;
        cyc("sw_f", F);
        cyc("sw_d", D);
        cyc("sw_ma", MA);
        cyc("sw_mw", MW);
        opcode = 7'b1101111;
        cyc("jal_f", F);
        cyc("jal_d", D);
        cyc("jal_x", J);
        opcode = 7'b1100011;
        cyc("beq0_f", F);
        cyc("beq0_d", D);
        zero_flag = 1'b0;
        cyc("beq0_br", BR);
        cyc("beq1_f", F);
        cyc("beq1_d", D);
        zero_flag = 1'b1;
        cyc("beq1_br", BR);
        zero_flag = 1'b0;
        opcode = 7'b0010011;
        cyc("i_f", F);
        cyc("i_d", D);
        cyc("i_ex", EI);
        cyc("i_wb", AWB);
        mem_ready = 1'b0;
        repeat (4) cyc("to_wait", F);
        flt_e = 1'b1;
        repeat (3) cyc("to_trap", T);
        mem_ready = 1'b1;
        cyc("to_trap_rdy", T);
        RST = 1'b1;
        flt_e = 1'b0;
        cyc("to_rst", R);
        RST = 1'b0;
        opcode = 7'b1110011;
        mem_ready = 1'b0;
        repeat (3) cyc("lim_wait", F);
        mem_ready = 1'b1;
        cyc("lim_done", F);
        cyc("ill_d", D);
        ill_e = 1'b1;
        repeat (20) cyc("ill_trap", T);
        RST = 1'b1;
        ill_e = 1'b0;
        cyc("ill_rst", R);
        RST = 1'b0;
        cyc("post_f", F);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
